// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and default sizes for the iterative mul/div unit.
// The register file reuses DEF_WIDTH and DEF_IDX_W.
package muldiv_unit_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_IDX_W = 4;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_MULHU = 2'd1,
        OP_DIVU  = 2'd2,
        OP_REMU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue-side request and register-file write-back bundle for muldiv_unit.
interface muldiv_unit_if #(
    parameter int WIDTH = muldiv_unit_pkg::DEF_WIDTH,
    parameter int IDX_W = muldiv_unit_pkg::DEF_IDX_W
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [IDX_W-1:0] dest;

    logic             busy;
    logic             done;
    logic             RegW;
    logic [IDX_W-1:0] DR;
    logic [WIDTH-1:0] Reg_in;

    modport master (
        output start, op, opa, opb, dest,
        input  busy, done, RegW, DR, Reg_in
    );

    modport slave (
        input  start, op, opa, opb, dest,
        output busy, done, RegW, DR, Reg_in
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide: one bit per cycle, WIDTH iterations,
// then a single-cycle register-file write-back.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input logic          CLK,
    input logic          RESET,
    muldiv_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   cnt;
    op_e                op_q;
    logic [IDX_W-1:0]   dest_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [IDX_W-1:0]   dr_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   result;

    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   rem_diff;
    logic               q_bit;
    logic               unused_diff;

    assign accept = (state == IDLE) && bus.start;
    assign last   = (state == RUN) && (cnt == LAST);
    assign hi     = acc[2*WIDTH-1:WIDTH];
    assign lo     = acc[WIDTH-1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (cnt == LAST) state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiply: acc = {partial, multiplier}; add multiplicand, shift right.
    // Divide: acc = {remainder, dividend->quotient}; restoring step.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        rem_sh   = {hi, lo[WIDTH-1]};
        rem_diff = {1'b0, rem_sh} - {2'b00, b_q};
        q_bit    = ~rem_diff[WIDTH+1];
        acc_nxt  = acc;
        if (op_is_div(op_q)) begin
            acc_nxt[2*WIDTH-1:WIDTH] = q_bit ? rem_diff[WIDTH-1:0]
                                             : rem_sh[WIDTH-1:0];
            acc_nxt[WIDTH-1:0] = {lo[WIDTH-2:0], q_bit};
        end else begin
            acc_nxt = {mul_sum, lo[WIDTH-1:1]};
        end
    end

    // Remainder after a successful subtract is below the divisor.
    assign unused_diff = rem_diff[WIDTH];

    always_comb begin
        result = acc_nxt[WIDTH-1:0];
        unique case (op_q)
            OP_MUL:   result = acc_nxt[WIDTH-1:0];
            OP_MULHU: result = acc_nxt[2*WIDTH-1:WIDTH];
            OP_DIVU:  result = acc_nxt[WIDTH-1:0];
            OP_REMU:  result = acc_nxt[2*WIDTH-1:WIDTH];
            default:  result = acc_nxt[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt    <= '0;
            op_q   <= OP_MUL;
            dest_q <= '0;
            b_q    <= '0;
            acc    <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= op_e'(bus.op);
            dest_q <= bus.dest;
            b_q    <= bus.op[1] ? bus.opb : bus.opa;
            acc    <= {{WIDTH{1'b0}}, bus.op[1] ? bus.opa : bus.opb};
        end else if (state == RUN) begin
            cnt    <= cnt + CNT_W'(1);
            acc    <= acc_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dr_q  <= '0;
            res_q <= '0;
        end else if (last) begin
            dr_q  <= dest_q;
            res_q <= result;
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.RegW   = (state == WB);
    assign bus.done   = (state == WB);
    assign bus.DR     = dr_q;
    assign bus.Reg_in = res_q;

endmodule
